delay_arb: RTL

DELAY_ARB -- requirements
Module: delay_arb

---
 rtl/delay_arb.sv | 126 ++++++++++++
 1 files changed

// File: rtl/delay_arb.sv
// Shared down-counting delay timer arbitrated among four requesters.
// Define DELAY_ARB_RR_EN for round-robin arbitration; the default is fixed priority.
module delay_arb #(
  parameter int CNT_W = 16,
  parameter int NREQ  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   count_in,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      done,
  output logic                 busy,
  output logic [31:0]          value,
  output logic [31:0]          debug
);

  // state | meaning
  // IDLE  | waiting for a request, timer held at 0
  // COUNT | timer running down for the granted requester
  // DONE  | delay expired, done pulse, back to IDLE next edge
  typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1, DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  timer_q;
  logic [1:0]        grant_q;
  logic [1:0]        win;
  logic [NREQ-1:0]   req_lat_q;
  logic [NREQ-1:0]   ack_q;
  logic [15:0]       cnt_q;

`ifdef DELAY_ARB_RR_EN
  logic [1:0] ptr_q;
  logic [1:0] idx;
  logic       found;

  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    win = '0;
    for (int k = 3; k >= 0; k--) begin
      if (req[k]) win = 2'(k);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Encoding 3 falls into the default arm and behaves as IDLE everywhere.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      COUNT:   state_d = (timer_q == '0) ? DONE : COUNT;
      DONE:    state_d = IDLE;
      default: state_d = (|req) ? COUNT : IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q   <= '0;
      grant_q   <= '0;
      req_lat_q <= '0;
      ack_q     <= '0;
      cnt_q     <= '0;
`ifdef DELAY_ARB_RR_EN
      ptr_q     <= '0;
`endif
    end else begin
      ack_q <= '0;
      case (state_q)
        COUNT: begin
          if (timer_q != '0) timer_q <= timer_q - CNT_W'(1);
        end
        DONE: begin
          timer_q <= '0;
          cnt_q   <= cnt_q + 16'd1;
`ifdef DELAY_ARB_RR_EN
          ptr_q   <= grant_q + 2'd1;
`endif
        end
        default: begin
          if (|req) begin
            timer_q   <= CNT_W'(count_in[{win, 4'b0000} +: 16]);
            grant_q   <= win;
            req_lat_q <= req;
            ack_q     <= NREQ'(1) << win;
          end else begin
            timer_q <= '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    ack   = ack_q;
    done  = '0;
    busy  = 1'b0;
    value = 32'(timer_q);
    debug = {state_q, grant_q, req_lat_q, 8'h00, cnt_q};
    case (state_q)
      COUNT: busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = NREQ'(1) << grant_q;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule
